// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory-like port among NUM_REQ requesters, one-cycle response.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic [ADDR_WIDTH-1:0]           address_o,
  output logic                            en_o,
  output logic                            we_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  input  logic [DATA_WIDTH-1:0]           data_i
);
  localparam int RW = $clog2(NUM_REQ);
  logic [RW-1:0]      base, g;
  logic [NUM_REQ-1:0] rot, owner_q;
  logic               any;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [RW-1:0] rr_q;
  assign base = rr_q;
  always_ff @(posedge clk_i)
    if (rst_i) rr_q <= '0;
    else if (any) rr_q <= (g == RW'(NUM_REQ-1)) ? '0 : g + RW'(1);
`endif
  // Rotate so the scan start sits at bit 0; the first set bit of rot wins.
  assign rot = NUM_REQ'({req_i, req_i} >> base);
  always_comb begin
    any = 1'b0;
    g   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (rot[k]) begin
        any = 1'b1;
        g   = RW'((int'(base) + k) % NUM_REQ);
      end
  end
  always_comb begin
    gnt_o     = '0;
    en_o      = any;
    we_o      = 1'b0;
    address_o = '0;
    data_o    = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (any && g == RW'(k)) begin
        gnt_o[k]  = 1'b1;
        we_o      = we_i[k];
        address_o = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        data_o    = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  always_ff @(posedge clk_i) owner_q <= rst_i ? '0 : gnt_o;
  assign rvalid_o = owner_q;
  assign rdata_o  = data_i;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i, we_i, gnt_o, rvalid_o;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [DW-1:0]   rdata_o, data_o, data_i;
  logic [AW-1:0]   address_o;
  logic            en_o, we_o;
  int              total = 0, fails = 0;
  int              ptr = 0;
  logic [N-1:0]    m_owner = '0;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .address_o(address_o), .en_o(en_o), .we_o(we_o), .data_o(data_o), .data_i(data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Winner is the first requesting index scanning upward from the pointer with wrap-around.
  function automatic int pick(input logic [N-1:0] r);
    int start;
`ifdef MEM_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_i[i] = r;
    we_i[i]  = w;
    addr_i[i*AW +: AW]  = a;
    wdata_i[i*DW +: DW] = d;
  endtask

  task automatic step(input logic r, input string tag);
    int w;
    logic [N-1:0] eg;
    rst_i = r;
    #1;
    w  = pick(req_i);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk({tag, ".gnt"}, 128'(gnt_o), 128'(eg));
    chk({tag, ".en"}, 128'(en_o), 128'(w >= 0));
    chk({tag, ".we"}, 128'(we_o), (w >= 0) ? 128'(we_i[w]) : 128'(0));
    chk({tag, ".addr"}, 128'(address_o), (w >= 0) ? 128'(addr_i[w*AW +: AW]) : 128'(0));
    chk({tag, ".data"}, 128'(data_o), (w >= 0) ? 128'(wdata_i[w*DW +: DW]) : 128'(0));
    chk({tag, ".rvalid"}, 128'(rvalid_o), 128'(m_owner));
    if (m_owner != '0) chk({tag, ".rdata"}, 128'(rdata_o), 128'(data_i));
    @(posedge clk);
    #1;
    m_owner = r ? '0 : eg;
    if (r) ptr = 0;
    else if (w >= 0) ptr = (w + 1) % N;
  endtask

  initial begin
    rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; data_i = '0;
    @(posedge clk);
    #1;
    step(1'b1, "rst");
    step(1'b1, "rst");
    for (int i = 0; i < 5; i++) step(1'b0, "idle");
    // single read by requester 1
    set_req(1, 1'b1, 1'b0, 64'h4000, 64'h0);
    #1;
    chk("rd.gnt_direct", 128'(gnt_o), 128'(2'b10));
    chk("rd.addr_direct", 128'(address_o), 128'h4000);
    step(1'b0, "rd");
    set_req(1, 1'b0, 1'b0, 64'h0, 64'h0);
    data_i = 64'hDEAD_BEEF;
    #1;
    chk("rd.rvalid_direct", 128'(rvalid_o), 128'(2'b10));
    chk("rd.rdata_direct", 128'(rdata_o), 128'hDEAD_BEEF);
    step(1'b0, "rd_rsp");
    // contention: requester 0 writes, requester 1 reads
    set_req(0, 1'b1, 1'b1, 64'h8, 64'h11);
    set_req(1, 1'b1, 1'b0, 64'h10, 64'h0);
    for (int i = 0; i < 4; i++) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
      #1;
      chk("rr.seq", 128'(gnt_o), (i % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
`endif
      step(1'b0, "rr");
    end
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    step(1'b0, "rr_drop0");
    set_req(1, 1'b0, 1'b0, 64'h0, 64'h0);
    step(1'b0, "rr_tail");
    step(1'b0, "rr_tail");
    // back-to-back single requester
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, 1'b0, 64'(i * 8), 64'h0);
      step(1'b0, "b2b");
    end
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    step(1'b0, "b2b_tail");
    // request withdrawn before any grant lands: nothing issued
    step(1'b0, "drop");
    // reset mid-flight with the pointer moved off 0
    set_req(0, 1'b1, 1'b0, 64'h20, 64'h0);
    step(1'b0, "mf_pre");
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(1, 1'b1, 1'b0, 64'h30, 64'h0);
    step(1'b1, "mf_rst");
    set_req(0, 1'b1, 1'b0, 64'h40, 64'h0);
    #1;
    chk("mf.rvalid_direct", 128'(rvalid_o), 128'(0));
    chk("mf.gnt_direct", 128'(gnt_o), 128'(2'b01));
    step(1'b0, "mf_post");
    // random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < N; j++)
        set_req(j, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom});
      data_i = {$urandom, $urandom};
      step($urandom_range(0, 31) == 0, "rand");
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
